ofifo_col_align: RTL
====================

// Module: ofifo_col_align
// PURPOSE
// Output FIFO between the MAC array and sfu1. Each array column pushes psum words on its
// own schedule; this block buffers them per column and realigns them into full rows.
// It presents a row to sfu1 as ofifo_out/ofifo_valid and pops on ofifo_rd.
// The read side is first-word-fall-through, because sfu1 samples ofifo_out on the same
// edge at which it asserts ofifo_rd.
// PARAMETERS
// col      8   number of array columns (lanes per row)
// psum_bw  16  bits per psum word
// depth    16  entries per column FIFO; power of 2, >= 2
// PORTS
// clk          in   1            clock; all logic is on the rising edge
// reset        in   1            asynchronous, active-high
// in           in   col*psum_bw  column psum words; lane i is in[(i+1)*psum_bw-1:i*psum_bw]
// wr           in   col          per-column push strobe
// ofifo_rd     in   1            pop one full row
// ofifo_out    out  col*psum_bw  head row; lane i is the head of column FIFO i
// ofifo_valid  out  1            every column FIFO is non-empty
// o_full       out  1            at least one column FIFO is full
// o_ready      out  1            no column FIFO is full (equals ~o_full)
// o_overflow   out  1            sticky: a push was dropped
// o_underflow  out  1            sticky: ofifo_rd arrived while ofifo_valid was low
// BEHAVIOUR
// - Column FIFO i: a storage array of depth x psum_bw.
//   - Read and write pointers are clog2(depth)+1 bits wide; the MSB is the wrap bit.
//   - empty_i when the two pointers are equal.
//   - full_i when the index bits are equal and the wrap bits differ.
// - Reset (async) clears all pointers and both sticky flags.
//   - Resulting outputs: ofifo_valid=0, o_full=0, o_ready=1, o_overflow=0, o_underflow=0.
//   - Storage contents are not reset; ofifo_out is don't-care while ofifo_valid=0.
//   - Reset asserted mid-stream discards all buffered data immediately.
// - Push: if wr[i] && !full_i at the edge, write lane i at wptr_i and increment wptr_i.
//   - The full check uses the pre-edge state. A push to a full column is dropped even
//     when a pop happens on the same edge. Dropping a push sets o_overflow.
//   - Only the addressed column is affected; other lanes still push normally.
// - ofifo_valid = AND over i of ~empty_i. This is combinational from the pointers and
//   does not depend on ofifo_rd.
// - ofifo_out lane i = mem_i[rptr_i], combinational (show-ahead).
//   - A row completed by pushes at edge N is valid and visible after edge N, i.e. 1 cycle
//     push-to-visible latency.
// - Pop: if ofifo_rd && ofifo_valid at the edge, increment every rptr_i together; rows
//   stay aligned.
//   - If ofifo_rd && !ofifo_valid: no pointer changes, and o_underflow is set.
// - Pointer increments wrap modulo 2*depth with no special cases.
// - Simultaneous push and pop on one non-full, non-empty column: both take effect and
//   that column's occupancy is unchanged.
// - Empty column with wr and ofifo_rd on the same edge: the pop is refused (ofifo_valid
//   was low) and the push succeeds.
// - Sticky flags are cleared only by reset.
// - ofifo_rd held high continuously drains one row per cycle while rows are available.
// TESTING
// (col=8, psum_bw=16, depth=4)
// 1. Reset check: after reset, ofifo_valid=0, o_ready=1, both sticky flags 0.
//    Assert reset mid-stream with 3 rows held -> all outputs return to reset values
//    without waiting for a clock edge.
// 2. Skewed columns: column i pushes value 16'h0100+i starting at cycle i.
//    -> ofifo_valid rises exactly 1 cycle after the column 7 push.
//    -> ofifo_out = {16'h0107,...,16'h0100}.
// 3. Fill and wrap: push 6 rows, value 16'h00r0+i (r = row, i = lane), popping
//    continuously. -> Rows come out in order 0..5 with no corruption across the
//    pointer wrap.
// 4. Overflow: push 5 times to column 3 only. -> o_full goes high after the 4th push,
//    the 5th push is dropped, o_overflow=1, and columns 0-2 and 4-7 are unaffected.
// 5. Underflow: ofifo_rd=1 with only column 0 holding data. -> o_underflow=1 and
//    column 0 occupancy stays at 1.
// 6. Full plus pop on the same edge: column 5 is full, wr[5] and a valid ofifo_rd
//    arrive on the same edge. -> The pop happens, the push is dropped, o_overflow=1,
//    and column 5 occupancy becomes 3.

Source files
------------

// File: rtl/ofifo_col_align_if.sv
// ofifo_col_align_if: column psum push bus and aligned-row pop bus of the output FIFO
interface ofifo_col_align_if #(parameter int col = 8, parameter int psum_bw = 16);
  logic [col*psum_bw-1:0] in;
  logic [col*psum_bw-1:0] ofifo_out;
  logic [col-1:0] wr;
  logic ofifo_rd;
  logic ofifo_valid;
  logic o_full;
  logic o_ready;
  logic o_overflow;
  logic o_underflow;
  modport master (output in, wr, ofifo_rd,
                  input ofifo_out, ofifo_valid, o_full, o_ready, o_overflow, o_underflow);
  modport slave (input in, wr, ofifo_rd,
                 output ofifo_out, ofifo_valid, o_full, o_ready, o_overflow, o_underflow);
endinterface

// File: rtl/ofifo_col_align.sv
// ofifo_col_align: per-column psum FIFOs realigned into full rows with show-ahead read
module ofifo_col_align #(
  parameter int col = 8,
  parameter int psum_bw = 16,
  parameter int depth = 16
) (
  input logic clk,
  input logic reset,
  ofifo_col_align_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] one = 1;
  logic [col-1:0] empty;
  logic [col-1:0] full;
  logic [col-1:0][psum_bw-1:0] row;
  logic valid;
  logic pop;
  logic overflow;
  logic underflow;
  assign valid = ~|empty;
  assign pop = bus.ofifo_rd && valid;
  for (genvar i = 0; i < col; i++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [aw:0] wptr;
    logic [aw:0] rptr;
    logic push;
    assign push = bus.wr[i] && !full[i];
    assign empty[i] = wptr == rptr;
    assign full[i] = wptr[aw-1:0] == rptr[aw-1:0] && wptr[aw] != rptr[aw];
    assign row[i] = mem[rptr[aw-1:0]];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + one;
        if (pop) rptr <= rptr + one;
      end
    // storage is deliberately left out of reset; pointers alone define contents
    always_ff @(posedge clk)
      if (push) mem[wptr[aw-1:0]] <= bus.in[i*psum_bw +: psum_bw];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (|(bus.wr & full)) overflow <= 1'b1;
      if (bus.ofifo_rd && !valid) underflow <= 1'b1;
    end
  assign bus.ofifo_out = row;
  assign bus.ofifo_valid = valid;
  assign bus.o_full = |full;
  assign bus.o_ready = ~|full;
  assign bus.o_overflow = overflow;
  assign bus.o_underflow = underflow;
endmodule
